// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the TDM deframer.
package tdm_pkg;

  // Receive alignment states: searching for a sync marker, or locked to frames.
  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 8;

  // Serial bits per frame: all channel slots plus an optional trailing parity bit.
  function automatic int frame_bits(input int num_ch, input int data_w, input bit parity_en);
    return num_ch * data_w + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit-position counter within a TDM frame. A sync load restarts the count at 1
// because the sync bit itself is bit 0; tc flags the last bit of the frame.
module tdm_slot_counter #(
  parameter int FRAME_BITS = 32,
  parameter int CW         = $clog2(FRAME_BITS + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          load,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  // Counter register: load beats clear beats increment.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(1);
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(FRAME_BITS - 1));

endmodule

// File: rtl/tdm_deframer.sv
// Receive side of the 4-channel TDM serial link: aligns on the frame-sync
// marker, shifts in each frame and presents the channel words over valid/ready.
// Optional feature macro: TDM_DEFRAMER_PARITY_EN adds a trailing even-parity bit
// per frame; frames failing the check are dropped and flagged on par_err.
module tdm_deframer
  import tdm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic                     in_bit,
  input  logic                     in_sync,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     locked,
  output logic                     sync_err,
  output logic                     overrun,
  output logic                     par_err
);

`ifdef TDM_DEFRAMER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int DATA_BITS  = NUM_CH * DATA_W;
  localparam int FRAME_BITS = frame_bits(NUM_CH, DATA_W, PAR_EN);
  localparam int CW         = $clog2(FRAME_BITS + 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        count;
  logic                 tc;
  logic                 cnt_clr, cnt_load, cnt_inc;
  logic                 sr_load, sr_shift;
  logic                 frame_done;
  logic                 sync_err_d;
  logic                 is_par_bit;
  logic                 par_ok;
  logic [DATA_BITS-1:0] sr;
  logic [DATA_BITS-1:0] frame_now;
  logic [DATA_BITS-1:0] cap_word;

  tdm_slot_counter #(
    .FRAME_BITS(FRAME_BITS),
    .CW        (CW)
  ) u_slot_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .load   (cnt_load),
    .inc    (cnt_inc),
    .count  (count),
    .tc     (tc)
  );

  // The parity bit sits just past the data bits and is never shifted in.
  assign is_par_bit = PAR_EN && (count == CW'(DATA_BITS));

  // Alignment FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-bit control decode; idle strobes leave everything alone.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    frame_done = 1'b0;
    sync_err_d = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_sync) begin
            state_d  = RECV;
            cnt_load = 1'b1;
            sr_load  = 1'b1;
          end
        end
        RECV: begin
          if (in_sync) begin
            // Sync anywhere but bit 0 restarts the frame on this bit.
            sync_err_d = (count != '0);
            cnt_load   = 1'b1;
            sr_load    = 1'b1;
          end else if (count == '0) begin
            // Expected a sync marker: alignment is lost.
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            sr_shift = !is_par_bit;
            if (tc) begin
              cnt_clr    = 1'b1;
              frame_done = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Frame shift register; a sync bit seeds it so any partial frame is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (sr_load) begin
      sr <= {{(DATA_BITS-1){1'b0}}, in_bit};
    end else if (sr_shift) begin
      sr <= {sr[DATA_BITS-2:0], in_bit};
    end
  end

  // Complete data bits of the frame being finished this cycle, then reorder so
  // the first-received slot (channel 0) lands in the low word.
  always_comb begin
    frame_now = PAR_EN ? sr : {sr[DATA_BITS-2:0], in_bit};
    par_ok    = PAR_EN ? ~(^sr ^ in_bit) : 1'b1;
    cap_word  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cap_word[k*DATA_W +: DATA_W] = frame_now[(NUM_CH-1-k)*DATA_W +: DATA_W];
    end
  end

  // Output holding register, handshake and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      overrun   <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      sync_err <= sync_err_d;
      par_err  <= frame_done && !par_ok;
      overrun  <= 1'b0;
      if (frame_done && par_ok) begin
        out_data  <= cap_word;
        out_valid <= 1'b1;
        overrun   <= out_valid && !out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign locked = (state_q == RECV);

endmodule

// File: doc/tdm_deframer.md
Name: tdm_deframer

Overview:
- Receive side of the team's 4-channel time-division-multiplexed serial link. The transmit side selects channels onto one wire; this block undoes that.
- Accepts a strobed serial bit stream with a frame-sync marker and counts bit/slot positions.
- Demultiplexes each frame into NUM_CH parallel channel words and presents them through a valid/ready handshake to downstream logic.

Parameters:
- NUM_CH, 4, number of TDM channel slots per frame (≥2)
- DATA_W, 8, bits per channel slot (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  strobe: in_bit/in_sync are sampled this cycle
- in_bit  input  1  serial data bit
- in_sync  input  1  marks the first bit of a frame; qualified by in_valid
- out_data  output  NUM_CH*DATA_W  channel k at [k*DATA_W +: DATA_W]
- out_valid  output  1  out_data holds a complete frame
- out_ready  input  1  downstream accepts out_data when out_valid&&out_ready
- locked  output  1  deframer aligned (state RECV)
- sync_err  output  1  one-cycle pulse on framing violation
- overrun  output  1  one-cycle pulse when an unconsumed frame is overwritten
- par_err  output  1  one-cycle pulse on parity mismatch (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): state HUNT, counters 0, shift register 0, out_data 0, out_valid 0, locked 0, all pulse outputs 0. Reset mid-frame discards the partial frame.
- Frame format: channel 0 first, each slot MSB first. FRAME_BITS = NUM_CH*DATA_W (+1 with parity).
- Cycles with in_valid=0 change no state and no counters.
- HUNT:
  - in_valid&&in_sync: bit accepted as bit 0, bit counter←1, go RECV.
  - in_valid&&!in_sync: bit ignored, no error.
- RECV (locked=1):
  - Each in_valid shifts in_bit and increments the bit counter.
  - in_sync at bit index ≠ 0: sync_err pulse, partial frame discarded, bit taken as bit 0 of a new frame, stay RECV.
  - Bit index 0 arriving without in_sync: sync_err pulse, bit dropped, go HUNT.
- Frame completion: on acceptance of bit FRAME_BITS-1, counter wraps to 0 and state stays RECV, so the next frame must begin with sync.
  - Data captured into out_data; out_valid=1 on the next clock edge (1-cycle latency after the last bit sample).
- Handshake:
  - out_valid stays high and out_data stays stable until out_valid&&out_ready; out_valid then clears next edge.
  - Completion while out_valid&&!out_ready: new frame overwrites, out_valid stays 1, overrun pulses.
  - Completion in the same cycle as out_valid&&out_ready: new frame loaded, out_valid stays 1, no overrun.
- Counter widths: $clog2(FRAME_BITS+1); no arithmetic overflow possible.

Optional Feature:
- Macro: TDM_DEFRAMER_PARITY_EN.
- Defined:
  - Frame carries one trailing even-parity bit covering all NUM_CH*DATA_W data bits.
  - On mismatch: par_err pulses the cycle after the parity bit, the frame is dropped (out_valid/out_data unchanged, no overrun), state stays RECV.
- Undefined:
  - No parity bit; FRAME_BITS = NUM_CH*DATA_W.
  - par_err tied 0.

Decomposition:
- Package tdm_pkg: state enum typedef (HUNT, RECV); default NUM_CH/DATA_W localparams; FRAME_BITS function.
- One natural sub-module, tdm_slot_counter: bit counter with enable, sync-load and terminal-count outputs.
- Shift/capture register, FSM and handshake stay in tdm_deframer.

Test Plan:
1. Reset, then one synced frame of slots 0xA5,0x3C,0xFF,0x01 with out_ready=1 → out_valid one cycle after last bit; out_data=32'h01FF3CA5; locked=1.
2. Back-to-back frames with in_valid gapped 1-of-3 cycles → both frames captured intact; gap cycles have no effect.
3. out_ready=0; two frames 0x11223344 then 0x55667788 → overrun pulses once; out_data=32'h55667788; drop out_ready once → out_valid clears next edge.
4. in_sync reasserted at bit 13 of a frame → sync_err pulse; subsequent 32 bits form a correct frame; next frame sent without sync → sync_err, locked=0.
5. Assert reset_n=0 mid-frame at bit 20 → all outputs 0 immediately; following synced frame decodes correctly.
6. With TDM_DEFRAMER_PARITY_EN, frame 0x000000FF: parity 0 → accepted; parity 1 → par_err pulse, out_valid stays 0.
